// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct codes, ALU controls, mux selects and FSM state encoding
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_JUMP    = 4'd10,
    S_HALT    = 4'd11
  } state_e;
endpackage

// File: rtl/mips_aludec.sv
// mips_aludec: R-type funct to ALU control, flags funct codes the core does not implement
module mips_aludec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       illegal
);
  // pure lookup; unknown funct falls back to add and raises illegal
  always_comb begin
    illegal = 1'b0;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLT:  alucontrol = ALU_SLT;
      default: begin
        alucontrol = ALU_ADD;
        illegal    = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM sharing one memory port, with retired-instruction counter
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcen,
  output logic [1:0]       pcsrc,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [2:0]       alucontrol,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);
  state_e           state_q, state_d, bad_next;
  logic             addi_q, addi_d, illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [2:0]       fn_alu;
  logic             fn_bad;
  logic             req_r, iord_r, mw_r, irw_r, srca_r, regdst_r, m2r_r, rw_r;
  logic             pcwrite, branch;
  logic [1:0]       pcsrc_r, srcb_r;
  logic [2:0]       aluc_r;
  mips_aludec u_aludec (
    .funct      (funct),
    .alucontrol (fn_alu),
    .illegal    (fn_bad)
  );
  assign bad_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
  // next state, addi tracking, sticky illegal flag and retire counting
  always_comb begin
    state_d   = state_q;
    addi_d    = addi_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        addi_d = (op == OP_ADDI);
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = bad_next;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: begin
        state_d   = fn_bad ? bad_next : S_ALUWB;
        illegal_d = illegal_q | fn_bad;
      end
      S_ADDIEX:  state_d = S_ALUWB;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, (state_d == S_FETCH) && (state_q != S_FETCH)};
  end
  // state and bookkeeping registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      addi_q    <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      addi_q    <= addi_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end
  // datapath controls decoded from the current state; handshake exits gated by mem_ready
  always_comb begin
    req_r    = 1'b0;
    iord_r   = 1'b0;
    mw_r     = 1'b0;
    irw_r    = 1'b0;
    srca_r   = 1'b0;
    regdst_r = 1'b0;
    m2r_r    = 1'b0;
    rw_r     = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    pcsrc_r  = PC_ALU;
    srcb_r   = SRCB_RT;
    aluc_r   = 3'b000;
    case (state_q)
      S_FETCH: begin
        req_r   = 1'b1;
        srcb_r  = SRCB_FOUR;
        aluc_r  = ALU_ADD;
        irw_r   = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: begin
        srcb_r = SRCB_IMMSH;
        aluc_r = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        srca_r = 1'b1;
        srcb_r = SRCB_IMM;
        aluc_r = ALU_ADD;
      end
      S_MEMRD: begin
        req_r  = 1'b1;
        iord_r = 1'b1;
      end
      S_MEMWB: begin
        m2r_r = 1'b1;
        rw_r  = 1'b1;
      end
      S_MEMWR: begin
        req_r  = 1'b1;
        iord_r = 1'b1;
        mw_r   = 1'b1;
      end
      S_RTYPEEX: begin
        srca_r = 1'b1;
        aluc_r = fn_alu;
      end
      S_ALUWB: begin
        regdst_r = ~addi_q;
        rw_r     = 1'b1;
      end
      S_BEQ: begin
        srca_r  = 1'b1;
        aluc_r  = ALU_SUB;
        pcsrc_r = PC_ALUOUT;
        branch  = 1'b1;
      end
      S_JUMP: begin
        pcsrc_r = PC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end
  assign mem_req    = reset & req_r;
  assign iord       = reset & iord_r;
  assign memwrite   = reset & mw_r;
  assign irwrite    = reset & irw_r;
  assign pcen       = reset & (pcwrite | (branch & zero));
  assign pcsrc      = reset ? pcsrc_r : 2'b00;
  assign alusrca    = reset & srca_r;
  assign alusrcb    = reset ? srcb_r : 2'b00;
  assign alucontrol = reset ? aluc_r : 3'b000;
  assign regdst     = reset & regdst_r;
  assign memtoreg   = reset & m2r_r;
  assign regwrite   = reset & rw_r;
  assign illegal_op = illegal_q;
  assign retired    = retired_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed scenario bench for the multicycle controller
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;
  // control word: req iord mw irw pcen pcsrc srca srcb alu regdst m2r rw illegal
  localparam logic [16:0] W_F   = 17'b1_0_0_1_1_00_0_01_010_0_0_0_0;
  localparam logic [16:0] W_FS  = 17'b1_0_0_0_0_00_0_01_010_0_0_0_0;
  localparam logic [16:0] W_D   = 17'b0_0_0_0_0_00_0_11_010_0_0_0_0;
  localparam logic [16:0] W_MA  = 17'b0_0_0_0_0_00_1_10_010_0_0_0_0;
  localparam logic [16:0] W_MR  = 17'b1_1_0_0_0_00_0_00_000_0_0_0_0;
  localparam logic [16:0] W_MW  = 17'b0_0_0_0_0_00_0_00_000_0_1_1_0;
  localparam logic [16:0] W_WR  = 17'b1_1_1_0_0_00_0_00_000_0_0_0_0;
  localparam logic [16:0] W_RX  = 17'b0_0_0_0_0_00_1_00_111_0_0_0_0;
  localparam logic [16:0] W_AW  = 17'b0_0_0_0_0_00_0_00_000_1_0_1_0;
  localparam logic [16:0] W_AWI = 17'b0_0_0_0_0_00_0_00_000_0_0_1_0;
  localparam logic [16:0] W_BT  = 17'b0_0_0_0_1_01_1_00_110_0_0_0_0;
  localparam logic [16:0] W_BN  = 17'b0_0_0_0_0_01_1_00_110_0_0_0_0;
  localparam logic [16:0] W_J   = 17'b0_0_0_0_1_10_0_00_000_0_0_0_0;
  localparam logic [16:0] W_H   = 17'b0_0_0_0_0_00_0_00_000_0_0_0_1;
  localparam logic [16:0] W_0   = 17'b0;
  localparam logic [16:0] ILL   = 17'b1;
  logic clk = 1'b0, reset = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] op = 6'b0, funct = 6'b0;
  logic mem_req, iord, memwrite, irwrite, pcen, alusrca, regdst, memtoreg, regwrite, illegal_op;
  logic [1:0] pcsrc, alusrcb;
  logic [2:0] alucontrol;
  logic [31:0] retired;
  logic mem_req_n, iord_n, memwrite_n, irwrite_n, pcen_n, alusrca_n, regdst_n, memtoreg_n, regwrite_n, illegal_op_n;
  logic [1:0] pcsrc_n, alusrcb_n;
  logic [2:0] alucontrol_n;
  logic [31:0] retired_n;
  int errs = 0, checks = 0;
  wire [16:0] ctl   = {mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb, alucontrol, regdst, memtoreg, regwrite, illegal_op};
  wire [16:0] ctl_n = {mem_req_n, iord_n, memwrite_n, irwrite_n, pcen_n, pcsrc_n, alusrca_n, alusrcb_n, alucontrol_n, regdst_n, memtoreg_n, regwrite_n, illegal_op_n};
  always #5 clk = ~clk;
  mips_multicycle_ctrl #(.CNT_W(32), .ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
    .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .illegal_op(illegal_op), .retired(retired)
  );
  mips_multicycle_ctrl #(.CNT_W(32), .ILLEGAL_HALT(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_n), .iord(iord_n), .memwrite(memwrite_n), .irwrite(irwrite_n), .pcen(pcen_n),
    .pcsrc(pcsrc_n), .alusrca(alusrca_n), .alusrcb(alusrcb_n), .alucontrol(alucontrol_n),
    .regdst(regdst_n), .memtoreg(memtoreg_n), .regwrite(regwrite_n), .illegal_op(illegal_op_n), .retired(retired_n)
  );
  task automatic do_reset;
    reset = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_reset;
    reset = 1'b0; op = OP_LW; mem_ready = 1'b1;
    #2;
    checks++; if (ctl !== W_0) begin errs++; $display("FAIL reset_outputs: got %b want %b", ctl, W_0); end
    checks++; if (retired !== 32'd0) begin errs++; $display("FAIL reset_retired: got %0d want 0", retired); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (ctl !== W_F) begin errs++; $display("FAIL reset_fetch: got %b want %b", ctl, W_F); end
  endtask
  task automatic test_lw;
    logic [16:0] e [5] = '{W_F, W_D, W_MA, W_MR, W_MW};
    do_reset();
    op = OP_LW; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (ctl !== e[i]) begin errs++; $display("FAIL lw_cycle%0d: got %b want %b", i + 1, ctl, e[i]); end
      @(negedge clk);
    end
    #1;
    checks++; if (retired !== 32'd1) begin errs++; $display("FAIL lw_retired: got %0d want 1", retired); end
    checks++; if (ctl !== W_F) begin errs++; $display("FAIL lw_refetch: got %b want %b", ctl, W_F); end
  endtask
  task automatic test_stall;
    do_reset();
    op = OP_J; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== W_FS) begin errs++; $display("FAIL stall_wait%0d: got %b want %b", i, ctl, W_FS); end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    checks++; if (ctl !== W_F) begin errs++; $display("FAIL stall_ready: got %b want %b", ctl, W_F); end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++; if (ctl !== W_D) begin errs++; $display("FAIL stall_decode: got %b want %b", ctl, W_D); end
    @(negedge clk);
    #1;
    checks++; if (ctl !== W_J) begin errs++; $display("FAIL jump: got %b want %b", ctl, W_J); end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    checks++; if (retired !== 32'd1) begin errs++; $display("FAIL jump_retired: got %0d want 1", retired); end
    checks++; if (ctl !== W_F) begin errs++; $display("FAIL jump_refetch: got %b want %b", ctl, W_F); end
  endtask
  task automatic test_beq;
    logic [16:0] e [3];
    do_reset();
    op = OP_BEQ; mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      zero = (k == 0);
      e = '{W_F, W_D, (k == 0) ? W_BT : W_BN};
      for (int i = 0; i < 3; i++) begin
        #1;
        checks++; if (ctl !== e[i]) begin errs++; $display("FAIL beq%0d_cycle%0d: got %b want %b", k, i + 1, ctl, e[i]); end
        @(negedge clk);
      end
      #1;
      checks++; if (retired !== 32'(k + 1)) begin errs++; $display("FAIL beq%0d_retired: got %0d want %0d", k, retired, k + 1); end
    end
  endtask
  task automatic test_rtype_addi;
    logic [16:0] er [4] = '{W_F, W_D, W_RX, W_AW};
    logic [16:0] ea [4] = '{W_F, W_D, W_MA, W_AWI};
    do_reset();
    op = OP_RTYPE; funct = FN_SLT; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ctl !== er[i]) begin errs++; $display("FAIL rtype_cycle%0d: got %b want %b", i + 1, ctl, er[i]); end
      @(negedge clk);
    end
    op = OP_ADDI;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ctl !== ea[i]) begin errs++; $display("FAIL addi_cycle%0d: got %b want %b", i + 1, ctl, ea[i]); end
      @(negedge clk);
    end
    #1;
    checks++; if (retired !== 32'd2) begin errs++; $display("FAIL rtype_addi_retired: got %0d want 2", retired); end
  endtask
  task automatic test_illegal;
    do_reset();
    op = 6'b111111; mem_ready = 1'b1;
    #1;
    checks++; if (ctl !== W_F) begin errs++; $display("FAIL ill_fetch: got %b want %b", ctl, W_F); end
    @(negedge clk);
    #1;
    checks++; if (ctl_n !== W_D) begin errs++; $display("FAIL ill_decode: got %b want %b", ctl_n, W_D); end
    @(negedge clk);
    mem_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++; if (ctl !== W_H) begin errs++; $display("FAIL ill_halt%0d: got %b want %b", i, ctl, W_H); end
      checks++; if (ctl_n !== (W_FS | ILL)) begin errs++; $display("FAIL ill_nop%0d: got %b want %b", i, ctl_n, W_FS | ILL); end
      @(negedge clk);
    end
    #1;
    checks++; if (retired !== 32'd0) begin errs++; $display("FAIL ill_halt_retired: got %0d want 0", retired); end
    checks++; if (retired_n !== 32'd1) begin errs++; $display("FAIL ill_nop_retired: got %0d want 1", retired_n); end
  endtask
  task automatic test_sw_reset;
    logic [16:0] e [4] = '{W_F, W_D, W_MA, W_WR};
    op = OP_SW; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl_n !== (e[i] | ILL)) begin errs++; $display("FAIL swr_cycle%0d: got %b want %b", i + 1, ctl_n, e[i] | ILL); end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl_n !== (W_WR | ILL)) begin errs++; $display("FAIL swr_stall%0d: got %b want %b", i, ctl_n, W_WR | ILL); end
      if (i < 2) @(negedge clk);
    end
    #1 reset = 1'b0;
    #1;
    checks++; if (ctl_n !== W_0) begin errs++; $display("FAIL swr_reset_out: got %b want %b", ctl_n, W_0); end
    checks++; if (retired_n !== 32'd0) begin errs++; $display("FAIL swr_reset_retired: got %0d want 0", retired_n); end
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    checks++; if (ctl_n !== W_F) begin errs++; $display("FAIL swr_release_nop: got %b want %b", ctl_n, W_F); end
    checks++; if (ctl !== W_F) begin errs++; $display("FAIL swr_release_halt: got %b want %b", ctl, W_F); end
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ctl !== e[i]) begin errs++; $display("FAIL sw_cycle%0d: got %b want %b", i + 1, ctl, e[i]); end
      @(negedge clk);
    end
    #1;
    checks++; if (retired !== 32'd1) begin errs++; $display("FAIL sw_retired: got %0d want 1", retired); end
    checks++; if (ctl !== W_F) begin errs++; $display("FAIL sw_refetch: got %b want %b", ctl, W_F); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_lw();
    test_stall();
    test_beq();
    test_rtype_addi();
    test_illegal();
    test_sw_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
